// File: rtl/datapath_unit_if.sv
// Control-word and result bundle between the control unit
// and the execution datapath.
interface datapath_unit_if #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8,
  parameter int RF_AW   = 4
);
  logic [DMEM_AW-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic               RF_W_en;
  logic [RF_AW-1:0]   RF_W_addr;
  logic [RF_AW-1:0]   RF_Ra_addr;
  logic [RF_AW-1:0]   RF_Rb_addr;
  logic [2:0]         ALU_s0;
  logic [DATA_W-1:0]  Ra_data;
  logic [DATA_W-1:0]  Rb_data;
  logic [DATA_W-1:0]  ALU_Out;
  logic [DATA_W-1:0]  Mem_q;
  logic [DATA_W-1:0]  W_data;
  logic               Zero;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_en,
    output RF_W_addr, RF_Ra_addr, RF_Rb_addr,
    output ALU_s0,
    input  Ra_data, Rb_data, ALU_Out,
    input  Mem_q, W_data, Zero
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_en,
    input  RF_W_addr, RF_Ra_addr, RF_Rb_addr,
    input  ALU_s0,
    output Ra_data, Rb_data, ALU_Out,
    output Mem_q, W_data, Zero
  );
endinterface

// File: rtl/datapath_unit.sv
// Execution datapath: register file, synchronous-read data
// memory, 8-function ALU and write-back mux.
module datapath_unit #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8,
  parameter int RF_AW   = 4
) (
  input  logic clk,
  input  logic reset,
  datapath_unit_if.slave dp
);
  localparam int RF_N = 2**RF_AW;
  localparam int DM_N = 2**DMEM_AW;

  logic [DATA_W-1:0] rf  [RF_N];
  logic [DATA_W-1:0] mem [DM_N];
  logic [DATA_W-1:0] mem_q;
  logic              zero_q;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] w_data;

  assign a = rf[dp.RF_Ra_addr];
  assign b = rf[dp.RF_Rb_addr];

  always_comb begin
    alu = '0;
    unique case (dp.ALU_s0)
      3'd0: alu = '0;
      3'd1: alu = a + b;
      3'd2: alu = a - b;
      3'd3: alu = a;
      3'd4: alu = a ^ b;
      3'd5: alu = a | b;
      3'd6: alu = a & b;
      3'd7: alu = a + 1'b1;
      default: alu = '0;
    endcase
  end

  assign w_data = dp.RF_s ? mem_q : alu;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RF_N; i++)
        rf[i] <= '0;
      zero_q <= 1'b0;
    end else if (dp.RF_W_en) begin
      rf[dp.RF_W_addr] <= w_data;
      if (!dp.RF_s)
        zero_q <= (alu == '0);
    end
  end

  // Memory array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && dp.D_wr)
      mem[dp.D_addr] <= a;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      mem_q <= '0;
    else
      mem_q <= mem[dp.D_addr];
  end

  assign dp.Ra_data = a;
  assign dp.Rb_data = b;
  assign dp.ALU_Out = alu;
  assign dp.Mem_q   = mem_q;
  assign dp.W_data  = w_data;
  assign dp.Zero    = zero_q;
endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed vector table, reset
// corner case, then random traffic against a model.
module tb_datapath_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  datapath_unit_if bus ();

  datapath_unit dut (
    .clk   (clk),
    .reset (reset),
    .dp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  w;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  op;
    logic        rs;
    logic        we;
    logic [7:0]  da;
    logic        dw;
    logic [15:0] e_alu;
    logic [15:0] e_w;
    logic        e_z;
    logic        cq;
    logic [15:0] e_q;
  } vec_t;

  vec_t tbl [21];

  logic [15:0] m_rf  [16];
  logic [15:0] m_mem [256];
  bit          m_ok  [256];
  logic [15:0] m_q;
  bit          m_qok;
  logic        m_z;

  function automatic vec_t mk(
    input logic [3:0] w, ra, rb,
    input logic [2:0] op,
    input logic rs, we,
    input logic [7:0] da,
    input logic dw,
    input logic [15:0] e_alu, e_w,
    input logic e_z, cq,
    input logic [15:0] e_q);
    vec_t v;
    v.w = w; v.ra = ra; v.rb = rb;
    v.op = op; v.rs = rs; v.we = we;
    v.da = da; v.dw = dw;
    v.e_alu = e_alu; v.e_w = e_w;
    v.e_z = e_z; v.cq = cq; v.e_q = e_q;
    return v;
  endfunction

  function automatic logic [15:0] ref_alu(
    input logic [2:0] op,
    input logic [15:0] x, y);
    int unsigned r;
    case (op)
      3'd1: r = x + y;
      3'd2: r = 32'h10000 + x - y;
      3'd3: r = x;
      3'd4: r = x ^ y;
      3'd5: r = x | y;
      3'd6: r = x & y;
      3'd7: r = x + 1;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [3:0] w, ra, rb,
    input logic [2:0] op,
    input logic rs, we,
    input logic [7:0] da,
    input logic dw);
    bus.RF_W_addr  = w;
    bus.RF_Ra_addr = ra;
    bus.RF_Rb_addr = rb;
    bus.ALU_s0     = op;
    bus.RF_s       = rs;
    bus.RF_W_en    = we;
    bus.D_addr     = da;
    bus.D_wr       = dw;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1,0,0,7,0,1,  0,0,16'h0001,16'h0001,0,0,0);
    tbl[1]  = mk(1,1,0,7,0,1,  0,0,16'h0002,16'h0002,0,0,0);
    tbl[2]  = mk(1,1,0,7,0,1,  0,0,16'h0003,16'h0003,0,0,0);
    tbl[3]  = mk(0,1,0,3,0,0, 11,1,16'h0003,16'h0003,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0, 11,0,16'h0000,16'h0000,0,1,3);
    tbl[5]  = mk(2,0,0,0,1,1, 11,0,16'h0000,16'h0003,0,1,3);
    tbl[6]  = mk(2,2,0,7,0,1,  0,0,16'h0004,16'h0004,0,0,0);
    tbl[7]  = mk(2,2,0,7,0,1,  0,0,16'h0005,16'h0005,0,0,0);
    tbl[8]  = mk(5,1,2,2,0,1,  0,0,16'hFFFE,16'hFFFE,0,0,0);
    tbl[9]  = mk(0,5,2,1,0,1,  0,0,16'h0003,16'h0003,0,0,0);
    tbl[10] = mk(0,1,2,4,0,0,  0,0,16'h0006,16'h0006,0,0,0);
    tbl[11] = mk(0,1,2,5,0,0,  0,0,16'h0007,16'h0007,0,0,0);
    tbl[12] = mk(0,1,2,6,0,0,  0,0,16'h0001,16'h0001,0,0,0);
    tbl[13] = mk(6,1,1,2,0,1,  0,0,16'h0000,16'h0000,1,0,0);
    tbl[14] = mk(0,0,0,0,0,0, 11,0,16'h0000,16'h0000,1,1,3);
    tbl[15] = mk(7,0,0,0,1,1, 11,0,16'h0000,16'h0003,1,1,3);
    tbl[16] = mk(0,5,0,3,0,0,205,1,16'hFFFE,16'hFFFE,1,0,0);
    tbl[17] = mk(0,1,0,3,0,0,205,1,16'h0003,16'h0003,1,1,
                 16'hFFFE);
    tbl[18] = mk(0,1,0,3,0,0,205,0,16'h0003,16'h0003,1,1,3);
    tbl[19] = mk(3,3,0,7,0,1,  0,0,16'h0001,16'h0001,0,0,0);
    tbl[20] = mk(0,3,0,3,0,0,  0,0,16'h0001,16'h0001,0,0,0);

    step();
    step();
    chk("rst_memq", bus.Mem_q, 16'h0000);
    chk("rst_zero", {15'd0, bus.Zero}, 16'h0000);
    chk("rst_ra0", bus.Ra_data, 16'h0000);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].w, tbl[i].ra, tbl[i].rb, tbl[i].op,
            tbl[i].rs, tbl[i].we, tbl[i].da, tbl[i].dw);
      #2;
      chk($sformatf("v%0d_alu", i), bus.ALU_Out,
          tbl[i].e_alu);
      chk($sformatf("v%0d_wdata", i), bus.W_data,
          tbl[i].e_w);
      step();
      chk($sformatf("v%0d_zero", i), {15'd0, bus.Zero},
          {15'd0, tbl[i].e_z});
      if (tbl[i].cq)
        chk($sformatf("v%0d_memq", i), bus.Mem_q,
            tbl[i].e_q);
    end

    // Reset lands on the write cycle of a load.
    drive(0, 0, 0, 0, 0, 0, 11, 0);
    step();
    drive(9, 0, 0, 0, 1, 1, 11, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_zero", {15'd0, bus.Zero}, 16'h0000);
    chk("mid_rst_memq", bus.Mem_q, 16'h0000);
    drive(0, 0, 0, 3, 0, 0, 11, 0);
    for (int r = 0; r < 16; r++) begin
      bus.RF_Ra_addr = 4'(r);
      #1;
      chk($sformatf("mid_rst_rf%0d", r), bus.Ra_data,
          16'h0000);
    end
    step();
    chk("mid_rst_mem11", bus.Mem_q, 16'h0003);

    // Random traffic against the model, from a fresh reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    foreach (m_rf[r]) m_rf[r] = '0;
    foreach (m_ok[k]) m_ok[k] = 1'b0;
    m_q   = '0;
    m_qok = 1'b1;
    m_z   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ea, eb, eal, ew, nq;
      logic [3:0]  w, ra, rb;
      logic [2:0]  op;
      logic        rs, we, dw, rn;
      logic [7:0]  da;
      bit          nok;
      w  = 4'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      op = 3'($urandom);
      we = 1'($urandom);
      dw = ($urandom_range(0, 2) == 0);
      da = 8'($urandom_range(0, 15));
      rs = m_qok ? 1'($urandom) : 1'b0;
      rn = ($urandom_range(0, 39) != 0);
      drive(w, ra, rb, op, rs, we, da, dw);
      reset = rn;
      ea  = m_rf[ra];
      eb  = m_rf[rb];
      eal = ref_alu(op, ea, eb);
      ew  = rs ? m_q : eal;
      #2;
      chk("rnd_ra", bus.Ra_data, ea);
      chk("rnd_rb", bus.Rb_data, eb);
      chk("rnd_alu", bus.ALU_Out, eal);
      chk("rnd_wdata", bus.W_data, ew);
      if (!rn) begin
        foreach (m_rf[r]) m_rf[r] = '0;
        m_q   = '0;
        m_qok = 1'b1;
        m_z   = 1'b0;
      end else begin
        nq  = m_mem[da];
        nok = m_ok[da];
        if (dw) begin
          m_mem[da] = ea;
          m_ok[da]  = 1'b1;
        end
        if (we) begin
          m_rf[w] = ew;
          if (!rs) m_z = (eal == 16'h0000);
        end
        m_q   = nq;
        m_qok = nok;
      end
      step();
      reset = 1'b1;
      chk("rnd_zero", {15'd0, bus.Zero}, {15'd0, m_z});
      if (m_qok)
        chk("rnd_memq", bus.Mem_q, m_q);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
